// File: rtl/bt_cmd_rx.sv
// UART (8N1) receiver for the Bluetooth link, decoding single-byte commands into
// a track select and a VS1003 SCI_VOL attenuation word.
module bt_cmd_rx #(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD      = 9600,
    parameter logic [7:0]  VOL_STEP  = 8'h10,
    parameter logic [7:0]  VOL_INIT  = 8'h20,
    parameter logic [7:0]  VOL_FLOOR = 8'hFE
) (
    input  logic        clk,
    input  logic        init_bt,
    input  logic        rxd,
    output logic [1:0]  num,
    output logic [15:0] volume,
    output logic [7:0]  rx_byte,
    output logic        rx_valid,
    output logic        cmd_valid,
    output logic        frame_err
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = (DIV > 2) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] DIV_M1   = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1  = CW'(HALF - 1);
    localparam logic [CW-1:0] CNT_ZERO = '0;
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_START = 3'd1,
        S_DATA  = 3'd2,
        S_STOP  = 3'd3,
        S_BREAK = 3'd4
    } state_t;

    state_t        state_r;
    logic [CW-1:0] cnt_r;
    logic [2:0]    bit_idx_r;
    logic [7:0]    shift_r;
    logic [7:0]    att_r;
    logic          rxd_meta_r;
    logic          rxs_r;

    logic [1:0]    num_nxt_s;
    logic [7:0]    att_nxt_s;
    logic          is_cmd_s;

    function automatic logic [7:0] att_louder(input logic [7:0] att);
        if (att < VOL_STEP) begin
            return 8'h00;
        end else begin
            return att - VOL_STEP;
        end
    endfunction

    function automatic logic [7:0] att_quieter(input logic [7:0] att);
        if (att > (VOL_FLOOR - VOL_STEP)) begin
            return VOL_FLOOR;
        end else begin
            return att + VOL_STEP;
        end
    endfunction

    // Two-flop synchroniser for the asynchronous serial line.
    always_ff @(posedge clk or negedge init_bt) begin
        if (!init_bt) begin
            rxd_meta_r <= 1'b1;
            rxs_r      <= 1'b1;
        end else begin
            rxd_meta_r <= rxd;
            rxs_r      <= rxd_meta_r;
        end
    end

    // Command decode of the fully assembled byte; only consumed on a good stop bit.
    always_comb begin
        num_nxt_s = num;
        att_nxt_s = att_r;
        is_cmd_s  = 1'b1;
        case (shift_r)
            8'h31, 8'h32, 8'h33, 8'h34: num_nxt_s = 2'(shift_r - 8'h31);
            8'h6E:                      num_nxt_s = num + 2'd1;
            8'h70:                      num_nxt_s = num - 2'd1;
            8'h2B:                      att_nxt_s = att_louder(att_r);
            8'h2D:                      att_nxt_s = att_quieter(att_r);
            default:                    is_cmd_s  = 1'b0;
        endcase
    end

    // Receive FSM; counter restarts on every state change, strobes last one cycle.
    always_ff @(posedge clk or negedge init_bt) begin
        if (!init_bt) begin
            state_r   <= S_IDLE;
            cnt_r     <= CNT_ZERO;
            bit_idx_r <= 3'd0;
            shift_r   <= 8'h00;
            att_r     <= VOL_INIT;
            num       <= 2'd0;
            rx_byte   <= 8'h00;
            rx_valid  <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_valid  <= 1'b0;
            cmd_valid <= 1'b0;
            frame_err <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    cnt_r <= CNT_ZERO;
                    if (!rxs_r) begin
                        state_r <= S_START;
                    end
                end
                S_START: begin
                    if (cnt_r == HALF_M1) begin
                        cnt_r     <= CNT_ZERO;
                        bit_idx_r <= 3'd0;
                        state_r   <= rxs_r ? S_IDLE : S_DATA;
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_DATA: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r            <= CNT_ZERO;
                        shift_r[bit_idx_r] <= rxs_r;
                        if (bit_idx_r == 3'd7) begin
                            state_r <= S_STOP;
                        end else begin
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_STOP: begin
                    if (cnt_r == DIV_M1) begin
                        cnt_r <= CNT_ZERO;
                        if (rxs_r) begin
                            rx_byte   <= shift_r;
                            rx_valid  <= 1'b1;
                            cmd_valid <= is_cmd_s;
                            num       <= num_nxt_s;
                            att_r     <= att_nxt_s;
                            state_r   <= S_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            state_r   <= S_BREAK;
                        end
                    end else begin
                        cnt_r <= cnt_r + CNT_ONE;
                    end
                end
                S_BREAK: begin
                    cnt_r <= CNT_ZERO;
                    if (rxs_r) begin
                        state_r <= S_IDLE;
                    end
                end
                default: begin
                    cnt_r   <= CNT_ZERO;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign volume = {att_r, att_r};

endmodule

// File: tb/tb_bt_cmd_rx.sv
// Randomised bench for bt_cmd_rx with a byte-level command model and a scoreboard
// of expected receive events, checked on every falling clock edge.
module tb_bt_cmd_rx;

    localparam int unsigned CLK_FREQ = 160;
    localparam int unsigned BAUD     = 10;
    localparam int          DIV      = CLK_FREQ / BAUD;

    logic        clk = 1'b0;
    logic        init_bt = 1'b0;
    logic        rxd = 1'b1;
    logic [1:0]  num;
    logic [15:0] volume;
    logic [7:0]  rx_byte;
    logic        rx_valid;
    logic        cmd_valid;
    logic        frame_err;

    bt_cmd_rx #(.CLK_FREQ(CLK_FREQ), .BAUD(BAUD)) dut (
        .clk(clk), .init_bt(init_bt), .rxd(rxd), .num(num), .volume(volume),
        .rx_byte(rx_byte), .rx_valid(rx_valid), .cmd_valid(cmd_valid), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    int n_pass = 0;
    int n_total = 0;
    int rv_cnt = 0;
    int fe_cnt = 0;

    // Model state: what num/att/rx_byte must be, and expected events {ferr, byte}.
    int         num_m = 0;
    int         att_m = 32;
    logic [7:0] byte_m = 8'h00;
    logic [8:0] exp_q[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
    endtask

    always @(negedge clk) begin
        if (init_bt) begin
            if (rx_valid) rv_cnt++;
            if (frame_err) fe_cnt++;
            if (rx_valid || frame_err) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_strobe", 32'd1, 32'd0);
                end else begin
                    logic [8:0] e;
                    int b;
                    bit cmd;
                    e = exp_q.pop_front();
                    chk("strobe_kind", {30'd0, rx_valid, frame_err}, e[8] ? 32'd1 : 32'd2);
                    if (!e[8]) begin
                        b = int'(e[7:0]);
                        cmd = 1'b1;
                        if (b >= 'h31 && b <= 'h34) num_m = b - 'h31;
                        else if (b == 'h6E) num_m = (num_m + 1) % 4;
                        else if (b == 'h70) num_m = (num_m + 3) % 4;
                        else if (b == 'h2B) att_m = (att_m < 16) ? 0 : att_m - 16;
                        else if (b == 'h2D) att_m = (att_m + 16 > 254) ? 254 : att_m + 16;
                        else cmd = 1'b0;
                        byte_m = e[7:0];
                        chk("cmd_valid", {31'd0, cmd_valid}, {31'd0, cmd});
                    end else begin
                        chk("cmd_valid_on_ferr", {31'd0, cmd_valid}, 32'd0);
                    end
                end
            end else begin
                chk("cmd_valid_alone", {31'd0, cmd_valid}, 32'd0);
            end
            chk("num", {30'd0, num}, 32'(num_m));
            chk("volume", {16'd0, volume}, 32'(att_m * 257));
            chk("rx_byte", {24'd0, rx_byte}, {24'd0, byte_m});
        end
    end

    task automatic drive(input logic v, input int n);
        rxd = v;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [7:0] b, input bit stop_ok, input int hold_low);
        exp_q.push_back({~stop_ok, b});
        drive(1'b0, DIV);
        for (int i = 0; i < 8; i++) drive(b[i], DIV);
        drive(stop_ok, DIV);
        if (!stop_ok) begin
            drive(1'b0, hold_low);
            rxd = 1'b1;
        end
    endtask

    task automatic drain();
        int k = 0;
        while (exp_q.size() != 0 && k < 4 * DIV) begin
            @(posedge clk);
            #1;
            k++;
        end
        chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        drive(1'b1, 4);
    endtask

    task automatic do_reset();
        init_bt = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        num_m = 0;
        att_m = 32;
        byte_m = 8'h00;
        drive(1'b1, 4);
        init_bt = 1'b1;
        drive(1'b1, 4);
    endtask

    initial begin
        logic [7:0] cmds [8];
        int r0, f0;
        cmds[0] = 8'h31; cmds[1] = 8'h32; cmds[2] = 8'h33; cmds[3] = 8'h34;
        cmds[4] = 8'h6E; cmds[5] = 8'h70; cmds[6] = 8'h2B; cmds[7] = 8'h2D;

        drive(1'b1, 3);
        chk("rst_num", {30'd0, num}, 32'd0);
        chk("rst_volume", {16'd0, volume}, 32'h2020);
        chk("rst_rx_byte", {24'd0, rx_byte}, 32'd0);
        chk("rst_strobes", {29'd0, rx_valid, cmd_valid, frame_err}, 32'd0);
        do_reset();

        send(8'h33, 1'b1, 0); drain();
        chk("lit_3_num", {30'd0, num}, 32'd2);
        chk("lit_3_vol", {16'd0, volume}, 32'h2020);
        chk("lit_3_byte", {24'd0, rx_byte}, 32'h33);
        chk("lit_3_rv", 32'(rv_cnt), 32'd1);

        send(8'h34, 1'b1, 0); send(8'h6E, 1'b1, 0); drain();
        chk("lit_n_wrap", {30'd0, num}, 32'd0);
        send(8'h70, 1'b1, 0); send(8'h70, 1'b1, 0); drain();
        chk("lit_pp", {30'd0, num}, 32'd2);

        do_reset();
        send(8'h2B, 1'b1, 0); drain();
        chk("lit_plus1", {16'd0, volume}, 32'h1010);
        send(8'h2B, 1'b1, 0); drain();
        chk("lit_plus2", {16'd0, volume}, 32'h0000);
        send(8'h2B, 1'b1, 0); drain();
        chk("lit_plus3", {16'd0, volume}, 32'h0000);
        for (int i = 0; i < 17; i++) send(8'h2D, 1'b1, 0);
        drain();
        chk("lit_minus17", {16'd0, volume}, 32'hFEFE);

        send(8'h41, 1'b1, 0); drain();
        chk("lit_A_byte", {24'd0, rx_byte}, 32'h41);
        chk("lit_A_num", {30'd0, num}, 32'd0);
        chk("lit_A_vol", {16'd0, volume}, 32'hFEFE);

        r0 = rv_cnt; f0 = fe_cnt;
        send(8'h55, 1'b0, 3 * DIV); drain();
        drive(1'b1, DIV);
        chk("break_ferr_cnt", 32'(fe_cnt - f0), 32'd1);
        chk("break_rv_cnt", 32'(rv_cnt - r0), 32'd0);
        send(8'h32, 1'b1, 0); drain();
        chk("lit_after_break", {30'd0, num}, 32'd1);

        r0 = rv_cnt; f0 = fe_cnt;
        for (int i = 1; i <= 5; i++) begin
            drive(1'b0, i);
            drive(1'b1, 2 * DIV);
        end
        chk("glitch_strobes", 32'(rv_cnt - r0 + fe_cnt - f0), 32'd0);

        for (int i = 0; i < 60; i++) begin
            logic [7:0] b;
            bit ok;
            b = ($urandom_range(0, 1) == 0) ? 8'($urandom_range(0, 255)) : cmds[$urandom_range(0, 7)];
            ok = ($urandom_range(0, 9) != 0);
            send(b, ok, ok ? 0 : $urandom_range(0, 2 * DIV));
            drive(1'b1, ok ? $urandom_range(0, 10) : DIV);
        end
        drain();

        send(8'h34, 1'b1, 0); drain();
        chk("lit_4_num", {30'd0, num}, 32'd3);
        drive(1'b0, DIV);
        drive(1'b1, DIV);
        drive(1'b0, 2 * DIV);
        init_bt = 1'b0;
        rxd = 1'b1;
        exp_q.delete();
        num_m = 0; att_m = 32; byte_m = 8'h00;
        drive(1'b1, 3);
        chk("midrst_num", {30'd0, num}, 32'd0);
        chk("midrst_vol", {16'd0, volume}, 32'h2020);
        init_bt = 1'b1;
        r0 = rv_cnt; f0 = fe_cnt;
        drive(1'b1, 3 * DIV);
        chk("midrst_quiet", 32'(rv_cnt - r0 + fe_cnt - f0), 32'd0);
        send(8'h70, 1'b1, 0); drain();
        chk("lit_p_wrap", {30'd0, num}, 32'd3);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bt_cmd_rx.md
Name: bt_cmd_rx

Overview:
- UART receiver and command decoder fed by the Bluetooth module's serial line `rxd` (8N1, idle high, LSB first).
- Converts received command bytes into `num`, the 2-bit track select, and `volume`, a 16-bit VS1003 SCI_VOL word (left and right attenuation bytes identical).
- Both outputs drive the mp3 player and the VGA display directly.
- Also exposes the raw byte and status strobes for debug.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz.
- BAUD, 9600, serial bit rate.
- VOL_STEP, 8'h10, attenuation change per volume command (per channel byte).
- VOL_INIT, 8'h20, per-channel attenuation after reset.
- VOL_FLOOR, 8'hFE, maximum attenuation (quietest).

Ports:
- clk  in  1  system clock.
- init_bt  in  1  asynchronous, active-low reset.
- rxd  in  1  asynchronous serial input, idle high.
- num  out  2  selected track index 0..3.
- volume  out  16  {att, att}, SCI_VOL format.
- rx_byte  out  8  last correctly framed byte.
- rx_valid  out  1  one-cycle pulse when rx_byte updates.
- cmd_valid  out  1  one-cycle pulse when the byte was a recognised command.
- frame_err  out  1  one-cycle pulse on a stop-bit error.

Behaviour:
- One clock, `clk`. `init_bt` low asynchronously clears all state regardless of the current state; any frame in progress is discarded.
- Reset values:
  - num = 2'd0, volume = {VOL_INIT, VOL_INIT} (16'h2020), rx_byte = 8'h00.
  - rx_valid = cmd_valid = frame_err = 0.
  - Synchroniser flops = 1, FSM = IDLE.
- Input synchronisation: `rxd` passes through a 2-flop synchroniser. All logic uses the synchronised value `rxs`.
- Timing constants:
  - DIV = CLK_FREQ/BAUD, integer division (10416 at the defaults). HALF = DIV/2.
  - The bit counter is wide enough for DIV-1. The baud counter runs only outside IDLE and resets on every state change.
- FSM:
  - IDLE: when rxs = 0, go to START with counter = 0.
  - START: at count HALF-1, if rxs = 0 go to DATA (bit index 0). If rxs = 1, the start was a glitch: return to IDLE and assert no strobe.
  - DATA: every DIV cycles, sample rxs into shift[bit index]. After bit 7, go to STOP.
  - STOP: after DIV cycles, sample rxs.
    - If rxs = 1: load rx_byte, pulse rx_valid, decode, go to IDLE.
    - If rxs = 0: pulse frame_err, leave outputs unchanged, go to BREAK.
  - BREAK: wait until rxs = 1, then go to IDLE. A held-low line (break) therefore produces exactly one frame_err.
- Decode: registered in the same edge that raises rx_valid, so outputs are valid the cycle rx_valid is high.
  - 8'h31–8'h34 ('1'–'4'): num = byte − 8'h31.
  - 8'h6E ('n'): num = num + 1, wrapping 3→0.
  - 8'h70 ('p'): num = num − 1, wrapping 0→3.
  - 8'h2B ('+', louder): att = (att < VOL_STEP) ? 8'h00 : att − VOL_STEP.
  - 8'h2D ('-', quieter): att = (att > VOL_FLOOR − VOL_STEP) ? VOL_FLOOR : att + VOL_STEP.
  - Any other byte: rx_valid pulses, cmd_valid stays 0, num and volume are unchanged.
  - cmd_valid pulses together with rx_valid for every recognised byte, including saturated volume commands and '1'–'4' when num is already equal.
- Strobes are each exactly one cycle wide. At most one of rx_valid and frame_err is high per frame.
- Back-to-back frames: a start bit that arrives immediately after the stop-bit sample is accepted. The next frame is detected within 1 cycle of IDLE plus the 2-cycle synchroniser delay.
- Latency: rx_valid rises about 9.5 bit times plus 3 cycles after the start bit's falling edge on `rxd`.

Test Plan:
- Reset, then send 0x33 ('3') at 9600 baud → rx_valid and cmd_valid pulse once; num = 2; volume = 16'h2020; rx_byte = 8'h33.
- From num = 3, send 'n' → num = 0. Then send 'p' twice → num = 2.
- From reset, send '+' three times → volume 16'h1010, then 16'h0000, then stays 16'h0000 with cmd_valid still pulsing. Then send '-' 17 times → volume saturates at 16'hFEFE.
- Send 0x41 ('A') → rx_valid = 1, cmd_valid = 0, num and volume unchanged.
- Send a frame with stop bit = 0, then hold the line low for 3 bit times → exactly one frame_err, no rx_valid. After the line returns high, a following '2' sets num = 1.
- Apply a 2000-cycle low glitch on an idle line → no strobes. Assert init_bt mid-frame after '4' was received → outputs return to num = 0, volume = 16'h2020.
